ca_rule_engine: RTL and testbench



---
 rtl/ca_pkg.sv | 28 ++
 rtl/ca_rule_engine_if.sv | 47 ++++
 rtl/ca_cell_rule.sv | 24 ++
 rtl/ca_rule_engine.sv | 157 +++++++++++++++
 tb/tb_ca_rule_engine.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ca_pkg
// Purpose  : Shared types and constants for the elementary cellular automaton
//            rule engine: boundary-mode encoding, FSM state encoding and the
//            Wolfram rule width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ca_pkg;

   localparam int RULE_W = 8;

   typedef enum logic [1:0] {
      BND_ZERO = 2'd0,
      BND_ONE  = 2'd1,
      BND_WRAP = 2'd2,
      BND_RSVD = 2'd3
   } boundary_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : ca_pkg
`default_nettype wire

// File: rtl/ca_rule_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ca_rule_engine_if
// Purpose  : Control/status bundle of the rule engine.
// Ports    : cfg_rule, cfg_boundary, cfg_halt_fixed  - run configuration
//            load_valid, load_state, load_ready       - initial-state load
//            start, num_gens                          - run request
//            busy, done, fixed_point, gen_count,
//            state_out                                - status / result
//            modport master : the controlling agent
//            modport slave  : the rule engine
// Revision : 1.0  initial release
// ============================================================================
interface ca_rule_engine_if #(
   parameter int N_CELLS = 16,
   parameter int GEN_W   = 16
);
   import ca_pkg::*;

   logic [RULE_W-1:0]  cfg_rule;
   logic [1:0]         cfg_boundary;
   logic               cfg_halt_fixed;
   logic               load_valid;
   logic [N_CELLS-1:0] load_state;
   logic               load_ready;
   logic               start;
   logic [GEN_W-1:0]   num_gens;
   logic               busy;
   logic               done;
   logic               fixed_point;
   logic [GEN_W-1:0]   gen_count;
   logic [N_CELLS-1:0] state_out;

   modport master (
      output cfg_rule, cfg_boundary, cfg_halt_fixed,
      output load_valid, load_state, start, num_gens,
      input  load_ready, busy, done, fixed_point, gen_count, state_out
   );

   modport slave (
      input  cfg_rule, cfg_boundary, cfg_halt_fixed,
      input  load_valid, load_state, start, num_gens,
      output load_ready, busy, done, fixed_point, gen_count, state_out
   );

endinterface : ca_rule_engine_if
`default_nettype wire

// File: rtl/ca_cell_rule.sv
`default_nettype none
// ============================================================================
// Module   : ca_cell_rule
// Purpose  : Next-state function of a single cell: the 3-bit neighbourhood
//            {left,self,right} selects one bit of the 8-bit Wolfram rule.
// Ports    : rule_i  [7:0] rule table
//            left_i, self_i, right_i  neighbourhood
//            next_o  next value of this cell
// Revision : 1.0  initial release
// ============================================================================
module ca_cell_rule
   import ca_pkg::*;
(
   input  wire logic [RULE_W-1:0] rule_i,
   input  wire logic              left_i,
   input  wire logic              self_i,
   input  wire logic              right_i,
   output logic                   next_o
);

   assign next_o = rule_i[{left_i, self_i, right_i}];

endmodule : ca_cell_rule
`default_nettype wire

// File: rtl/ca_rule_engine.sv
`default_nettype none
// ============================================================================
// Module   : ca_rule_engine
// Purpose  : N-cell one-dimensional elementary cellular automaton. Loads an
//            initial state, then evolves it one generation per clock under a
//            latched Wolfram rule and boundary mode, for a requested number
//            of generations or until a fixed point is reached.
// Ports    : clk  system clock, rising edge
//            rst  asynchronous active-high reset
//            bus  ca_rule_engine_if.slave (config, load, start, status)
// Revision : 1.0  initial release
// ============================================================================
module ca_rule_engine
   import ca_pkg::*;
#(
   parameter int N_CELLS = 16,
   parameter int GEN_W   = 16
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ca_rule_engine_if.slave bus
);

   state_e             fsm_q;
   logic [RULE_W-1:0]  rule_q;
   boundary_e          bnd_q;
   logic               halt_q;
   logic [GEN_W-1:0]   target_q;
   logic [GEN_W-1:0]   gen_count_q;
   logic [N_CELLS-1:0] state_out_q;
   logic               load_ready_q;
   logic               busy_q;
   logic               done_q;
   logic               fixed_q;

   logic               left_edge;
   logic               right_edge;
   logic [N_CELLS+1:0] ext_state;
   logic [N_CELLS-1:0] state_d;
   logic [GEN_W-1:0]   gen_count_d;
   logic               last_gen;
   logic               at_fixed;

   // Neighbours seen beyond the ends of the register.
   always_comb begin
      left_edge  = 1'b0;
      right_edge = 1'b0;
      case (bnd_q)
         BND_ONE: begin
            left_edge  = 1'b1;
            right_edge = 1'b1;
         end
         BND_WRAP: begin
            left_edge  = state_out_q[0];
            right_edge = state_out_q[N_CELLS-1];
         end
         default: begin
            left_edge  = 1'b0;
            right_edge = 1'b0;
         end
      endcase
   end

   // Padding with the edge bits lets every cell use the same indexing:
   // cell i sees ext_state[i+2:i] as {left, self, right}.
   assign ext_state = {left_edge, state_out_q, right_edge};

   generate
      for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
         ca_cell_rule u_cell (
            .rule_i  (rule_q),
            .left_i  (ext_state[gi+2]),
            .self_i  (ext_state[gi+1]),
            .right_i (ext_state[gi]),
            .next_o  (state_d[gi])
         );
      end
   endgenerate

   // gen_count_q stays below target_q while running, so the increment
   // cannot wrap even when the target is the all-ones value.
   assign gen_count_d = gen_count_q + GEN_W'(1);
   assign last_gen    = (gen_count_d == target_q);
   assign at_fixed    = halt_q && (state_d == state_out_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q        <= IDLE;
         rule_q       <= '0;
         bnd_q        <= BND_ZERO;
         halt_q       <= 1'b0;
         target_q     <= '0;
         gen_count_q  <= '0;
         state_out_q  <= '0;
         load_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fixed_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (bus.load_valid && load_ready_q) begin
                  state_out_q <= bus.load_state;
               end
               if (bus.start) begin
                  rule_q       <= bus.cfg_rule;
                  bnd_q        <= boundary_e'(bus.cfg_boundary);
                  halt_q       <= bus.cfg_halt_fixed;
                  target_q     <= bus.num_gens;
                  gen_count_q  <= '0;
                  fixed_q      <= 1'b0;
                  load_ready_q <= 1'b0;
                  if (bus.num_gens == '0) begin
                     fsm_q  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     fsm_q  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               state_out_q <= state_d;
               gen_count_q <= gen_count_d;
               if (last_gen || at_fixed) begin
                  fsm_q  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  if (at_fixed) begin
                     fixed_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               fsm_q        <= IDLE;
               done_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
            default: begin
               fsm_q        <= IDLE;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.load_ready  = load_ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fixed_point = fixed_q;
   assign bus.gen_count   = gen_count_q;
   assign bus.state_out   = state_out_q;

endmodule : ca_rule_engine
`default_nettype wire

// File: tb/tb_ca_rule_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_rule_engine
// Purpose  : Directed self-checking bench for ca_rule_engine (8 cells).
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_ca_rule_engine;

   localparam int N_CELLS = 8;
   localparam int GEN_W   = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ca_rule_engine_if #(.N_CELLS(N_CELLS), .GEN_W(GEN_W)) bus ();

   ca_rule_engine #(.N_CELLS(N_CELLS), .GEN_W(GEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      bus.load_valid = 1'b1;
      bus.load_state = v;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] rule, input logic [1:0] bnd,
                           input logic halt, input logic [15:0] gens);
      bus.cfg_rule       = rule;
      bus.cfg_boundary   = bnd;
      bus.cfg_halt_fixed = halt;
      bus.num_gens       = gens;
      bus.start          = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Ticks until done; returns edges after the start edge and busy cycles seen.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && edges < 200) begin
         if (bus.busy === 1'b1) busy_cycles++;
         tick();
         edges++;
      end
   endtask

   int e;
   int b;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.cfg_rule = '0;
      bus.cfg_boundary = '0;
      bus.cfg_halt_fixed = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_state = '0;
      bus.start = 1'b0;
      bus.num_gens = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset values
      check("rst_state", 32'(bus.state_out), 32'h0);
      check("rst_ready", 32'(bus.load_ready), 32'h1);
      check("rst_busy",  32'(bus.busy), 32'h0);
      check("rst_done",  32'(bus.done), 32'h0);
      check("rst_gen",   32'(bus.gen_count), 32'h0);
      check("rst_fixed", 32'(bus.fixed_point), 32'h0);

      // Rule 0x1C, one generation, load and start in the same cycle
      bus.load_valid = 1'b1;
      bus.load_state = 8'h10;
      do_start(8'h1C, 2'd0, 1'b0, 16'd1);
      bus.load_valid = 1'b0;
      check("r1c_busy", 32'(bus.busy), 32'h1);
      check("r1c_ready", 32'(bus.load_ready), 32'h0);
      wait_done(e, b);
      check("r1c_latency", 32'(e), 32'd1);
      check("r1c_busycyc", 32'(b), 32'd1);
      check("r1c_state", 32'(bus.state_out), 32'h18);
      check("r1c_gen", 32'(bus.gen_count), 32'd1);
      tick();
      check("r1c_done_pulse", 32'(bus.done), 32'h0);
      check("r1c_ready_back", 32'(bus.load_ready), 32'h1);

      // Rule 0x5A, two generations; cfg changes during RUN are ignored
      do_load(8'h10);
      do_start(8'h5A, 2'd0, 1'b0, 16'd2);
      bus.cfg_rule = 8'h00;
      bus.cfg_boundary = 2'd1;
      check("r5a_busy0", 32'(bus.busy), 32'h1);
      tick();
      check("r5a_gen1", 32'(bus.state_out), 32'h28);
      check("r5a_busy1", 32'(bus.busy), 32'h1);
      tick();
      check("r5a_gen2", 32'(bus.state_out), 32'h44);
      check("r5a_done", 32'(bus.done), 32'h1);
      check("r5a_busy2", 32'(bus.busy), 32'h0);
      check("r5a_cnt", 32'(bus.gen_count), 32'd2);
      tick();

      // Rule 0xAA (copy right neighbour) under each boundary mode
      do_load(8'h81);
      do_start(8'hAA, 2'd2, 1'b0, 16'd1);
      wait_done(e, b);
      check("raa_wrap", 32'(bus.state_out), 32'h03);
      tick();
      do_load(8'h81);
      do_start(8'hAA, 2'd0, 1'b0, 16'd1);
      wait_done(e, b);
      check("raa_zero", 32'(bus.state_out), 32'h02);
      tick();
      do_load(8'h81);
      do_start(8'hAA, 2'd1, 1'b0, 16'd1);
      wait_done(e, b);
      check("raa_one", 32'(bus.state_out), 32'h03);
      tick();
      do_load(8'h81);
      do_start(8'hAA, 2'd3, 1'b0, 16'd1);
      wait_done(e, b);
      check("raa_rsvd", 32'(bus.state_out), 32'h02);
      tick();

      // Identity rule with halt: stops after one generation on a fixed point
      do_load(8'h5A);
      do_start(8'hCC, 2'd0, 1'b1, 16'd10);
      wait_done(e, b);
      check("halt_latency", 32'(e), 32'd1);
      check("halt_gen", 32'(bus.gen_count), 32'd1);
      check("halt_fixed", 32'(bus.fixed_point), 32'h1);
      check("halt_state", 32'(bus.state_out), 32'h5A);
      tick();
      check("halt_sticky", 32'(bus.fixed_point), 32'h1);

      // Zero generations: straight to DONE, state unchanged
      do_start(8'hFF, 2'd1, 1'b0, 16'd0);
      check("zero_done", 32'(bus.done), 32'h1);
      check("zero_busy", 32'(bus.busy), 32'h0);
      check("zero_gen", 32'(bus.gen_count), 32'd0);
      check("zero_state", 32'(bus.state_out), 32'h5A);
      check("zero_fixclr", 32'(bus.fixed_point), 32'h0);
      tick();

      // Load ignored during RUN, then reset three cycles into the run
      do_start(8'hCC, 2'd0, 1'b0, 16'd10);
      bus.load_valid = 1'b1;
      bus.load_state = 8'hFF;
      tick();
      tick();
      check("run_noload", 32'(bus.state_out), 32'h5A);
      check("run_gen2", 32'(bus.gen_count), 32'd2);
      check("run_busy", 32'(bus.busy), 32'h1);
      bus.load_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_state", 32'(bus.state_out), 32'h0);
      check("mid_rst_gen", 32'(bus.gen_count), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'h0);
      check("mid_rst_ready", 32'(bus.load_ready), 32'h1);
      check("mid_rst_done", 32'(bus.done), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", 32'(bus.busy), 32'h0);
      check("post_rst_ready", 32'(bus.load_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ca_rule_engine
`default_nettype wire
